mux_rr_stream: RTL

//  Parametrised N-channel, W-bit streaming multiplexer. It is the registered, handshaked successor of the 8:1 bit mux.

---
 rtl/mux_rr_stream_if.sv | 29 ++
 rtl/mux_rr_stream.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mux_rr_stream_if.sv
// Handshake bundle for mux_rr_stream: per-channel input streams, the manual
// select/mode controls and the single registered output stream.
interface mux_rr_stream_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;

    // Producer/consumer side (drives the inputs, observes the outputs).
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel streaming multiplexer with a single-entry output
// register. Channel choice is manual (sel) or round-robin (mode=1).
// Optional feature macro MUX_STATS_EN adds per-channel 16-bit saturating
// transfer counters readable through stat_sel/stat_cnt.
module mux_rr_stream #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_stream_if.slave   bus
`ifdef MUX_STATS_EN
    ,
    input  logic [SEL_W-1:0] stat_sel,
    output logic [15:0]      stat_cnt
`endif
);

    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e                 state_q, state_d;
    logic [SEL_W-1:0]      rr_ptr;
    logic                  rr_hit;
    logic [SEL_W-1:0]      rr_win;
    logic [2**SEL_W-1:0]   vld_ext;
    logic                  cand_vld;
    logic [SEL_W-1:0]      cand;
    logic                  free;
    logic                  grant;
    logic [DATA_W-1:0]     data_p1;
    logic [SEL_W-1:0]      ch_p1;

    // Round-robin search: first valid channel after rr_ptr, wrapping at NUM_CH-1.
    always_comb begin
        int idx;
        idx    = 0;
        rr_hit = 1'b0;
        rr_win = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!rr_hit && bus.in_valid[idx]) begin
                rr_hit = 1'b1;
                rr_win = SEL_W'(idx);
            end
        end
    end

    // Candidate selection and grant; out-of-range sel reads a zero valid bit.
    always_comb begin
        vld_ext      = (2**SEL_W)'(bus.in_valid);
        cand         = bus.mode ? rr_win : bus.sel;
        cand_vld     = bus.mode ? rr_hit : vld_ext[bus.sel];
        free         = (state_q == EMPTY) || bus.out_ready;
        grant        = rst_n && free && cand_vld;
        bus.in_ready = grant ? (NUM_CH'(1) << cand) : '0;
    end

    // Output slot next state: fill on grant, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL: begin
                if (grant)              state_d = FULL;
                else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Stage p1: capture the granted word and its channel index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (grant) begin
            data_p1 <= bus.in_data[cand*DATA_W +: DATA_W];
            ch_p1   <= cand;
        end
    end

    // Round-robin pointer advances only on round-robin grants.
    always_ff @(posedge clk) begin
        if (!rst_n)                rr_ptr <= SEL_W'(NUM_CH - 1);
        else if (grant && bus.mode) rr_ptr <= cand;
    end

    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;
    assign bus.out_valid = (state_q == FULL);

`ifdef MUX_STATS_EN
    logic [15:0] cnt [NUM_CH];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Per-channel handshake counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rst_n)                                cnt[k] <= '0;
            else if (bus.in_valid[k] && bus.in_ready[k]) cnt[k] <= sat_inc(cnt[k]);
        end
    end

    // Counter read port; indices past the last channel read zero.
    always_comb begin
        stat_cnt = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (stat_sel == SEL_W'(k)) stat_cnt = cnt[k];
    end
`endif

endmodule
